pam4_tx_symbol_gen: RTL

- Transmit-side PAM4 symbol source for the SERDES simulation chain.
- Produces framed streams of signed symbols from {-3, -1, +1, +3}.
- Each frame is a fixed alternating-sync preamble followed by a PRBS31-derived payload.
- Drives the receive path's noisy-channel input through a valid/ready handshake; the channel applies level scaling and noise.

---
 rtl/pam4_tx_symbol_gen_if.sv | 10 +
 rtl/pam4_tx_symbol_gen.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pam4_tx_symbol_gen_if.sv
// Symbol-stream handshake between the PAM4 transmit source (master) and the channel model (slave).
interface pam4_tx_symbol_gen_if;
    logic signed [7:0] sym_out;
    logic              sym_valid;
    logic              sym_is_preamble;
    logic              sym_ready;

    modport master (output sym_out, output sym_valid, output sym_is_preamble, input sym_ready);
    modport slave  (input sym_out, input sym_valid, input sym_is_preamble, output sym_ready);
endinterface

// File: rtl/pam4_tx_symbol_gen.sv
// PAM4 transmit symbol source: alternating +3/-3 preamble, then a PRBS31 payload (two bits per symbol).
// Define PAM4_GRAY_CODE_EN for Gray level mapping; the default build uses binary mapping.
module pam4_tx_symbol_gen #(
    parameter int unsigned PREAMBLE_LEN = 64,
    parameter int unsigned FRAME_LEN    = 1024,
    parameter logic [30:0] SEED         = 31'h7FFF_FFFF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  start,
    input  logic                  abort,
    pam4_tx_symbol_gen_if.master  sym,
    output logic                  frame_done,
    output logic                  busy,
    output logic [15:0]           frame_count
);
    typedef enum logic [1:0] {IDLE, PREAM, PAYLD} state_t;

    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] PAY_LAST = 16'(FRAME_LEN - 1);

    state_t            state;
    logic [30:0]       lfsr;
    logic [15:0]       cnt;
    logic signed [7:0] out_sym;
    logic              out_valid;
    logic              out_pre;
    logic              xfer;
    logic [1:0]        pair;
    logic [30:0]       lfsr_next;

    function automatic logic signed [7:0] map_sym(input logic [1:0] b);
        // NOTE: the default arm covers every code, so no latch can be inferred from this decode.
        case (b)
`ifdef PAM4_GRAY_CODE_EN
            2'b00:   map_sym = -8'sd3;
            2'b01:   map_sym = -8'sd1;
            2'b11:   map_sym =  8'sd1;
            default: map_sym =  8'sd3;
`else
            2'b00:   map_sym = -8'sd3;
            2'b01:   map_sym = -8'sd1;
            2'b10:   map_sym =  8'sd1;
            default: map_sym =  8'sd3;
`endif
        endcase
    endfunction

    assign xfer      = en && out_valid && sym.sym_ready;
    // Two Fibonacci steps at once: b1 is the first new bit, b0 the second.
    assign pair      = {lfsr[30] ^ lfsr[27], lfsr[29] ^ lfsr[26]};
    assign lfsr_next = {lfsr[28:0], pair};

    assign sym.sym_out         = out_sym;
    assign sym.sym_valid       = out_valid;
    assign sym.sym_is_preamble = out_pre;
    assign busy                = (state != IDLE);

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            lfsr        <= SEED;
            cnt         <= '0;
            out_sym     <= '0;
            out_valid   <= 1'b0;
            out_pre     <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else if (en) begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state     <= PREAM;
                        lfsr      <= SEED;
                        cnt       <= '0;
                        out_sym   <= 8'sd3;
                        out_valid <= 1'b1;
                        out_pre   <= 1'b1;
                    end
                end
                PREAM: begin
                    if (abort) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_pre   <= 1'b0;
                    end else if (xfer) begin
                        if (cnt == PRE_LAST) begin
                            state   <= PAYLD;
                            cnt     <= '0;
                            out_sym <= map_sym(pair);
                            out_pre <= 1'b0;
                            lfsr    <= lfsr_next;
                        end else begin
                            cnt     <= cnt + 16'd1;
                            out_sym <= cnt[0] ? 8'sd3 : -8'sd3;
                        end
                    end
                end
                PAYLD: begin
                    if (abort) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end else if (xfer) begin
                        if (cnt == PAY_LAST) begin
                            state       <= IDLE;
                            out_valid   <= 1'b0;
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end else begin
                            cnt     <= cnt + 16'd1;
                            out_sym <= map_sym(pair);
                            lfsr    <= lfsr_next;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_pre   <= 1'b0;
                end
            endcase
        end
    end
endmodule
